// File: rtl/top_frame_timestamp.sv
// Frame-start timestamper: counts timer ticks and queues the tick count for each frame edge.
// Optional TOP_FRAME_TS_FRAME_COUNT_EN adds a 16-bit frame counter readable at address 7.
module top_frame_timestamp #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FIFO_AW    = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick_in,
    input  logic        frame_start,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    logic               tick_d, frame_d;
    logic               tick_edge, frame_edge;
    logic               ctrl_en, ctrl_irq_en;
    logic [31:0]        tick_cnt;
    logic [15:0]        tick_shadow;
    logic               overflow;
    logic [FIFO_AW:0]   wr_ptr, rd_ptr, level;
    logic [31:0]        mem [FIFO_DEPTH];
    logic [31:0]        head;
    logic               not_empty, full;
    logic               wr_stb, rd_stb, clr;
    logic               push_req, push, pop, drop;
    logic [15:0]        frame_word;
    logic [15:0]        rd_mux;
    logic               unused_wdata;

    assign tick_edge  = tick_in & ~tick_d;
    assign frame_edge = frame_start & ~frame_d;
    assign wr_stb     = chipselect & ~write_n;
    assign rd_stb     = chipselect & ~read_n;
    assign clr        = wr_stb && (address == 3'd1) && writedata[2];

    assign level      = wr_ptr - rd_ptr;
    assign not_empty  = (level != '0);
    assign full       = (level == (FIFO_AW+1)'(FIFO_DEPTH));
    assign head       = mem[rd_ptr[FIFO_AW-1:0]];

    // Pop requires data; a full FIFO accepts a push only when a pop frees a slot that cycle.
    assign pop        = rd_stb && (address == 3'd3) && not_empty;
    assign push_req   = frame_edge & ctrl_en;
    assign drop       = push_req & full & ~pop;
    assign push       = push_req & ~drop;

    assign unused_wdata = ^writedata[15:3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_d      <= 1'b0;
            frame_d     <= 1'b0;
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            tick_cnt    <= '0;
            tick_shadow <= '0;
            overflow    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            readdata    <= '0;
            irq         <= 1'b0;
        end else begin
            tick_d  <= tick_in;
            frame_d <= frame_start;
            if (wr_stb && address == 3'd1) begin
                ctrl_en     <= writedata[0];
                ctrl_irq_en <= writedata[1];
            end
            if (clr) begin
                tick_cnt <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (ctrl_en && tick_edge)
                    tick_cnt <= tick_cnt + 32'd1;
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (drop)
                    overflow <= 1'b1;
                else if (wr_stb && address == 3'd0)
                    overflow <= 1'b0;
            end
            if (rd_stb && address == 3'd4)
                tick_shadow <= tick_cnt[31:16];
            readdata <= rd_mux;
            irq      <= ctrl_irq_en & (not_empty | overflow);
        end
    end

    // Pushed value is the pre-increment count, since tick_cnt updates on the same edge.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[FIFO_AW-1:0]] <= tick_cnt;
    end

`ifdef TOP_FRAME_TS_FRAME_COUNT_EN
    logic [15:0] frame_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            frame_cnt <= '0;
        else if (clr)
            frame_cnt <= '0;
        else if (push_req)
            frame_cnt <= frame_cnt + 16'd1;
    end

    assign frame_word = frame_cnt;
`else
    assign frame_word = '0;
`endif

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0: rd_mux = {13'b0, not_empty, overflow, not_empty};
            3'd1: rd_mux = {14'b0, ctrl_irq_en, ctrl_en};
            3'd2: rd_mux = head[15:0];
            3'd3: rd_mux = not_empty ? head[31:16] : 16'h0000;
            3'd4: rd_mux = tick_cnt[15:0];
            3'd5: rd_mux = tick_shadow;
            3'd6: rd_mux = 16'(level);
            3'd7: rd_mux = frame_word;
            default: rd_mux = '0;
        endcase
    end

endmodule

// File: tb/tb_top_frame_timestamp.sv
// Scoreboard bench for top_frame_timestamp: directed Avalon reads with queued expectations.
`timescale 1ns/1ps
module tb_top_frame_timestamp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tick_in;
    logic        frame_start;
    logic [2:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    always #5 clk = ~clk;

    top_frame_timestamp #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick_in     (tick_in),
        .frame_start (frame_start),
        .address     (address),
        .chipselect  (chipselect),
        .read_n      (read_n),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .irq         (irq)
    );

    typedef struct {
        string       name;
        logic [15:0] exp;
    } exp_t;

    exp_t rd_q[$];
    exp_t irq_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic rd_vld  = 1'b0;
    logic peek    = 1'b0;
    logic irq_chk = 1'b0;

`ifdef TOP_FRAME_TS_FRAME_COUNT_EN
    localparam logic [15:0] FRAME_CNT_EXP = 16'd10;
`else
    localparam logic [15:0] FRAME_CNT_EXP = 16'd0;
`endif

    // A read strobe seen at an edge means readdata holds its answer until the next edge.
    always @(posedge clk) rd_vld <= chipselect & ~read_n;

    always @(negedge clk) begin
        exp_t e;
        if (rd_vld || peek) begin
            n_tests++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read got=%h required=none", readdata);
            end else begin
                e = rd_q.pop_front();
                if (readdata !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s got=%h required=%h", e.name, readdata, e.exp);
                end
            end
        end
        if (irq_chk) begin
            n_tests++;
            if (irq_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_irq_check got=%b required=none", irq);
            end else begin
                e = irq_q.pop_front();
                if (irq !== e.exp[0]) begin
                    n_fail++;
                    $display("FAIL %s got=%b required=%b", e.name, irq, e.exp[0]);
                end
            end
        end
    end

    task automatic push_exp(input bit to_irq, input string n, input logic [15:0] v);
        exp_t e;
        e.name = n;
        e.exp  = v;
        if (to_irq) irq_q.push_back(e);
        else        rd_q.push_back(e);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] v, input string n);
        @(posedge clk); #1;
        push_exp(1'b0, n, v);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    // Frame edge coinciding with a TS_H read strobe.
    task automatic frame_rd(input logic [15:0] v, input string n);
        @(posedge clk); #1;
        push_exp(1'b0, n, v);
        address = 3'd3; chipselect = 1'b1; read_n = 1'b0; frame_start = 1'b1;
        @(posedge clk); #1;
        chipselect = 1'b0; read_n = 1'b1; frame_start = 1'b0;
    endtask

    task automatic pulse(input logic t, input logic f);
        @(posedge clk); #1;
        tick_in = t; frame_start = f;
        @(posedge clk); #1;
        tick_in = 1'b0; frame_start = 1'b0;
    endtask

    task automatic chk_irq(input logic v, input string n);
        @(posedge clk); #1;
        push_exp(1'b1, n, {15'b0, v});
        irq_chk = 1'b1;
        @(negedge clk); #1;
        irq_chk = 1'b0;
    endtask

    task automatic peek_reset(input string n);
        push_exp(1'b0, {n, "_readdata"}, 16'h0000);
        push_exp(1'b1, {n, "_irq"}, 16'h0000);
        peek = 1'b1; irq_chk = 1'b1;
        @(negedge clk); #1;
        peek = 1'b0; irq_chk = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; tick_in = 1'b0; frame_start = 1'b0; address = '0;
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; writedata = '0;
        peek_reset("reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // 1: five ticks then one frame
        wr(3'd1, 16'h0001);
        repeat (5) pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        rd(3'd6, 16'd1, "t1_level");
        rd(3'd2, 16'd5, "t1_ts_l");
        rd(3'd3, 16'd0, "t1_ts_h");
        rd(3'd6, 16'd0, "t1_level_after_pop");
        rd(3'd4, 16'd5, "t1_tick_l");

        // 2: overflow with nine frames into depth 8
        wr(3'd1, 16'h0003);
        repeat (9) pulse(1'b0, 1'b1);
        rd(3'd6, 16'd8, "t2_level");
        rd(3'd0, 16'h0007, "t2_status");
        chk_irq(1'b1, "t2_irq");
        wr(3'd0, 16'h0000);
        rd(3'd0, 16'h0005, "t2_status_cleared");
        rd(3'd2, 16'd5, "t2_ts_l");

        // 3: clr, then simultaneous tick and frame at tick_cnt=7
        wr(3'd1, 16'h0007);
        rd(3'd6, 16'd0, "t3_level_clr");
        rd(3'd4, 16'd0, "t3_tick_clr");
        chk_irq(1'b0, "t3_irq_clr");
        rd(3'd0, 16'h0000, "t3_status_clr");
        rd(3'd1, 16'h0003, "t3_ctrl");
        repeat (7) pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        rd(3'd2, 16'd7, "t3_ts_l");
        rd(3'd3, 16'd0, "t3_ts_h");
        rd(3'd4, 16'd8, "t3_tick_l");
        rd(3'd5, 16'd0, "t3_tick_h");
        rd(3'd6, 16'd0, "t3_level");

        // 4: wrap from 0xFFFFFFFF
        @(negedge clk);
        force dut.tick_cnt = 32'hFFFF_FFFF;
        #1 release dut.tick_cnt;
        rd(3'd4, 16'hFFFF, "t4_tick_l_max");
        rd(3'd5, 16'hFFFF, "t4_tick_h_max");
        pulse(1'b1, 1'b0);
        rd(3'd5, 16'hFFFF, "t4_shadow_held");
        rd(3'd4, 16'h0000, "t4_tick_l_wrap");
        rd(3'd5, 16'h0000, "t4_tick_h_wrap");

        // 5: full FIFO with same-cycle push and pop
        for (int i = 0; i < 8; i++) begin
            pulse(1'b0, 1'b1);
            pulse(1'b1, 1'b0);
        end
        rd(3'd6, 16'd8, "t5_level_full");
        rd(3'd0, 16'h0005, "t5_status_full");
        rd(3'd2, 16'd0, "t5_ts_l0");
        frame_rd(16'd0, "t5_ts_h_pushpop");
        rd(3'd6, 16'd8, "t5_level_pushpop");
        rd(3'd0, 16'h0005, "t5_status_no_ovf");
        rd(3'd2, 16'd1, "t5_ts_l1");
        rd(3'd3, 16'd0, "t5_ts_h1");
        rd(3'd2, 16'd2, "t5_ts_l2");
        wr(3'd1, 16'h0007);
        rd(3'd6, 16'd0, "t5_level_clr");
        rd(3'd4, 16'd0, "t5_tick_clr");
        chk_irq(1'b0, "t5_irq_clr");

        // empty FIFO: push proceeds, pop suppressed
        pulse(1'b1, 1'b0);
        frame_rd(16'd0, "t5_ts_h_empty");
        rd(3'd6, 16'd1, "t5_level_empty_pushpop");
        rd(3'd2, 16'd1, "t5_ts_l_empty_pushpop");

        // en=0 freezes count and ignores frames
        wr(3'd1, 16'h0002);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        rd(3'd6, 16'd1, "t5_level_frozen");
        rd(3'd4, 16'd1, "t5_tick_frozen");
        chk_irq(1'b1, "t5_irq_frozen");

        // 6: frame counter with two dropped pushes
        wr(3'd1, 16'h0007);
        repeat (10) pulse(1'b0, 1'b1);
        rd(3'd7, FRAME_CNT_EXP, "t6_frame_cnt");
        rd(3'd6, 16'd8, "t6_level");
        rd(3'd0, 16'h0007, "t6_status");
        chk_irq(1'b1, "t6_irq");

        // reset mid-operation
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1 peek_reset("midreset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        rd(3'd6, 16'd0, "midreset_level");
        rd(3'd7, 16'd0, "midreset_frame_cnt");
        rd(3'd1, 16'd0, "midreset_ctrl");

        repeat (3) @(posedge clk);
        for (int i = 0; i < 50 && (rd_q.size() != 0 || irq_q.size() != 0); i++)
            @(posedge clk);
        if (rd_q.size() != 0 || irq_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain pending=%0d required=0", rd_q.size() + irq_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
